// File: rtl/frac_divider.sv
`default_nettype none
// ============================================================================
// Module   : frac_divider
// Brief    : Dual-modulus fractional clock divider, ratio Whole + Dec/100.
// Revision : 1.0 - initial release
// ============================================================================

module frac_divider (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        En,
  input  logic        Load,
  input  logic [31:0] C_N1,
  output logic        Div_Pulse,
  output logic        Div_Clk,
  output logic        Load_Ack,
  output logic [25:0] Period
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [24:0] MIN_WHOLE = 25'd2;
  localparam logic [6:0]  MAX_DEC   = 7'd99;
  localparam logic [7:0]  MODULUS   = 8'd100;

  logic [0:0]  state;
  logic [24:0] whole_sh;
  logic [6:0]  dec_sh;
  logic        load_pend;
  logic [25:0] cnt;
  logic [6:0]  acc;

  logic [24:0] cap_whole;
  logic [6:0]  cap_dec;
  logic [24:0] use_whole;
  logic [6:0]  use_dec;
  logic [7:0]  sum;
  logic [7:0]  sum_wrap;
  logic        carry;
  logic [6:0]  next_acc;
  logic [25:0] next_p;
  logic        reload;

  always_comb begin
    cap_whole = (C_N1[31:7] < MIN_WHOLE) ? MIN_WHOLE : C_N1[31:7];
    cap_dec   = (C_N1[6:0] > MAX_DEC) ? MAX_DEC : C_N1[6:0];
    // A Load on a reload edge feeds that very reload (write-through).
    use_whole = Load ? cap_whole : whole_sh;
    use_dec   = Load ? cap_dec   : dec_sh;
    sum       = {1'b0, acc} + {1'b0, use_dec};
    sum_wrap  = sum - MODULUS;
    carry     = (sum >= MODULUS);
    next_acc  = carry ? sum_wrap[6:0] : sum[6:0];
    next_p    = {1'b0, use_whole} + {25'd0, carry};
    reload    = En && ((state == IDLE) || (cnt == 26'd0));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      whole_sh  <= MIN_WHOLE;
      dec_sh    <= 7'd0;
      load_pend <= 1'b0;
      Load_Ack  <= 1'b0;
    end else begin
      if (Load) begin
        whole_sh <= cap_whole;
        dec_sh   <= cap_dec;
      end
      if (reload) begin
        load_pend <= 1'b0;
      end else if (Load) begin
        load_pend <= 1'b1;
      end
      Load_Ack <= reload && (Load || load_pend);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= 26'd0;
      acc       <= 7'd0;
      Period    <= 26'd0;
      Div_Pulse <= 1'b0;
      Div_Clk   <= 1'b0;
    end else if (state == IDLE) begin
      Div_Pulse <= 1'b0;
      Div_Clk   <= 1'b0;
      if (En) begin
        state     <= RUN;
        cnt       <= next_p - 26'd1;
        acc       <= next_acc;
        Period    <= next_p;
        Div_Clk   <= 1'b1;
      end
    end else begin
      if (!En) begin
        state     <= IDLE;
        cnt       <= 26'd0;
        acc       <= 7'd0;
        Period    <= 26'd0;
        Div_Pulse <= 1'b0;
        Div_Clk   <= 1'b0;
      end else if (cnt == 26'd0) begin
        cnt       <= next_p - 26'd1;
        acc       <= next_acc;
        Period    <= next_p;
        Div_Pulse <= 1'b1;
        Div_Clk   <= 1'b1;
      end else begin
        cnt       <= cnt - 26'd1;
        Div_Pulse <= 1'b0;
        // High while the cycle about to start is within the first ceil(P/2).
        Div_Clk   <= (cnt > {1'b0, Period[25:1]});
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_frac_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_frac_divider
// Brief    : Self-checking bench for frac_divider (vectors, corners, random).
// Revision : 1.0 - initial release
// ============================================================================

module tb_frac_divider;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        En;
  logic        Load;
  logic [31:0] C_N1;
  logic        Div_Pulse;
  logic        Div_Clk;
  logic        Load_Ack;
  logic [25:0] Period;

  frac_divider dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .En        (En),
    .Load      (Load),
    .C_N1      (C_N1),
    .Div_Pulse (Div_Pulse),
    .Div_Clk   (Div_Clk),
    .Load_Ack  (Load_Ack),
    .Period    (Period)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: position k counts up through a period of length m_p.
  bit m_run;
  bit m_pend;
  bit m_ack;
  int m_acc, m_k, m_p, m_nper, m_wh, m_dc;

  typedef struct {
    bit          en;
    bit          ld;
    logic [31:0] v;
    bit          p;
    bit          c;
    bit          a;
    int          per;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [31:0] mk(input int w, input int d);
    logic [31:0] r;
    r = {w[24:0], d[6:0]};
    return r;
  endfunction

  function automatic void model_reset();
    m_run = 0; m_pend = 0; m_ack = 0;
    m_acc = 0; m_k = 0; m_p = 0; m_nper = 0; m_wh = 2; m_dc = 0;
  endfunction

  function automatic void model_reload(input bit ld, input int lw, input int ldc);
    int wh, dc, s;
    wh = ld ? lw : m_wh;
    dc = ld ? ldc : m_dc;
    s  = m_acc + dc;
    if (s >= 100) begin m_p = wh + 1; m_acc = s - 100; end
    else          begin m_p = wh;     m_acc = s;       end
    m_k = 0;
    m_nper++;
    m_ack  = m_pend || ld;
    m_pend = 0;
  endfunction

  function automatic void model_edge(input bit en, input bit ld, input logic [31:0] v);
    int lw, ldc;
    lw  = int'(v[31:7]);
    ldc = int'(v[6:0]);
    if (lw < 2) lw = 2;
    if (ldc > 99) ldc = 99;
    m_ack = 0;
    if (!m_run) begin
      if (en) begin
        m_run  = 1;
        m_nper = 0;
        model_reload(ld, lw, ldc);
      end
    end else if (!en) begin
      m_run = 0; m_acc = 0; m_k = 0; m_p = 0;
    end else begin
      m_k++;
      if (m_k == m_p) model_reload(ld, lw, ldc);
    end
    if (ld) begin
      m_wh = lw;
      m_dc = ldc;
      if (!m_ack) m_pend = 1;
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    check("model_pulse",  int'(Div_Pulse), (m_run && m_k == 0 && m_nper > 1) ? 1 : 0);
    check("model_divclk", int'(Div_Clk),   (m_run && m_k < (m_p + 1) / 2) ? 1 : 0);
    check("model_ack",    int'(Load_Ack),  m_ack ? 1 : 0);
    check("model_period", int'(Period),    m_run ? m_p : 0);
  endtask

  task automatic step(input bit en, input bit ld, input logic [31:0] v);
    @(negedge Clk);
    En = en; Load = ld; C_N1 = v;
    @(posedge Clk);
    model_edge(en, ld, v);
    #1;
    cmp_model();
  endtask

  // Reset is raised mid-cycle so outputs are checked before any clock edge.
  task automatic do_reset();
    @(negedge Clk);
    #2;
    Reset = 1'b1; En = 1'b0; Load = 1'b0;
    #1;
    model_reset();
    check("rst_pulse",  int'(Div_Pulse), 0);
    check("rst_divclk", int'(Div_Clk),   0);
    check("rst_ack",    int'(Load_Ack),  0);
    check("rst_period", int'(Period),    0);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic run_until_pulse(input int budget, output int n);
    n = 0;
    do begin
      step(1'b1, 1'b0, 32'd0);
      n++;
    end while (!Div_Pulse && n < budget);
  endtask

  initial begin
    int n, cnt2, cnt3;
    int pers[$];

    Reset = 1'b1; En = 1'b0; Load = 1'b0; C_N1 = 32'd0;
    model_reset();
    #12;
    Reset = 1'b0;

    // Integer divide by 4, loaded while idle.
    tbl[0]  = '{0, 1, mk(4, 0), 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 32'd0,    0, 1, 1, 4};
    tbl[2]  = '{1, 0, 32'd0,    0, 1, 0, 4};
    tbl[3]  = '{1, 0, 32'd0,    0, 0, 0, 4};
    tbl[4]  = '{1, 0, 32'd0,    0, 0, 0, 4};
    tbl[5]  = '{1, 0, 32'd0,    1, 1, 0, 4};
    tbl[6]  = '{1, 0, 32'd0,    0, 1, 0, 4};
    tbl[7]  = '{1, 0, 32'd0,    0, 0, 0, 4};
    tbl[8]  = '{1, 0, 32'd0,    0, 0, 0, 4};
    tbl[9]  = '{1, 0, 32'd0,    1, 1, 0, 4};
    tbl[10] = '{0, 0, 32'd0,    0, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].en, tbl[i].ld, tbl[i].v);
      check("tbl_pulse",  int'(Div_Pulse), int'(tbl[i].p));
      check("tbl_divclk", int'(Div_Clk),   int'(tbl[i].c));
      check("tbl_ack",    int'(Load_Ack),  int'(tbl[i].a));
      check("tbl_period", int'(Period),    tbl[i].per);
    end

    // Ratio 2.50: 40 pulses over 100 edges after RUN entry.
    do_reset();
    step(0, 1, mk(2, 50));
    step(1, 0, 32'd0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step(1, 0, 32'd0);
      if (Div_Pulse) n++;
    end
    check("half_pulses", n, 40);

    // Ratio 3.25: 100 pulses over 325 edges.
    do_reset();
    step(0, 1, mk(3, 25));
    step(1, 0, 32'd0);
    n = 0;
    for (int i = 0; i < 325; i++) begin
      step(1, 0, 32'd0);
      if (Div_Pulse) n++;
    end
    check("quarter_pulses", n, 100);

    // Clamping 1 / 120 -> 2.99: one P=2 then 99 P=3, then P=2 again.
    do_reset();
    step(0, 1, mk(1, 120));
    step(1, 0, 32'd0);
    pers.push_back(int'(Period));
    n = 0;
    while (pers.size() < 101 && n < 1000) begin
      step(1, 0, 32'd0);
      n++;
      if (Div_Pulse) pers.push_back(int'(Period));
    end
    check("clamp_periods_seen", pers.size(), 101);
    cnt2 = 0; cnt3 = 0;
    for (int i = 1; i < pers.size() && i < 100; i++) begin
      if (pers[i] == 3) cnt3++;
      if (pers[i] == 2) cnt2++;
    end
    check("clamp_first", pers[0], 2);
    check("clamp_threes", cnt3, 99);
    check("clamp_twos_mid", cnt2, 0);
    if (pers.size() > 100) check("clamp_repeat", pers[100], 2);

    // Mid-period load: 6-cycle period completes, then 8 with a single ack.
    do_reset();
    step(0, 1, mk(6, 0));
    step(1, 0, 32'd0);
    run_until_pulse(20, n);
    check("mid_first_period", n, 6);
    step(1, 0, 32'd0);
    step(1, 0, 32'd0);
    step(1, 1, mk(8, 0));
    run_until_pulse(20, n);
    check("mid_old_period", n + 3, 6);
    check("mid_new_period_val", int'(Period), 8);
    check("mid_ack", int'(Load_Ack), 1);
    run_until_pulse(20, n);
    check("mid_new_period_len", n, 8);
    check("mid_ack_once", int'(Load_Ack), 0);

    // Load coinciding with a reload is used by that reload.
    do_reset();
    step(0, 1, mk(4, 0));
    step(1, 0, 32'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 32'd0);
    step(1, 1, mk(7, 0));
    check("wt_period", int'(Period), 7);
    check("wt_ack", int'(Load_Ack), 1);
    check("wt_pulse", int'(Div_Pulse), 1);

    // Reset mid-period, then restart; first pulse 5 edges after entry.
    do_reset();
    step(0, 1, mk(5, 0));
    step(1, 0, 32'd0);
    step(1, 0, 32'd0);
    step(1, 0, 32'd0);
    do_reset();
    step(0, 1, mk(5, 0));
    step(1, 0, 32'd0);
    check("rst_restart_period", int'(Period), 5);
    run_until_pulse(20, n);
    check("rst_restart_first_pulse", n, 5);

    // One edge of En low returns to IDLE and clears the accumulator.
    do_reset();
    step(0, 1, mk(2, 50));
    step(1, 0, 32'd0);
    for (int i = 0; i < 7; i++) step(1, 0, 32'd0);
    step(0, 0, 32'd0);
    check("en_low_period", int'(Period), 0);
    step(1, 0, 32'd0);
    check("en_restart_p0", int'(Period), 2);
    run_until_pulse(20, n);
    check("en_restart_len", n, 2);
    check("en_restart_p1", int'(Period), 3);

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 15) != 0),
             ($urandom_range(0, 9) == 0),
             mk($urandom_range(0, 9), $urandom_range(0, 127)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
